se_instr_mem: RTL and testbench



---
 rtl/se_pkg.sv | 12 +
 rtl/se_imem_array.sv | 30 +++
 rtl/se_instr_mem.sv | 55 +++++
 tb/tb_se_instr_mem.sv | 136 +++++++++++++
 4 files changed

// File: rtl/se_pkg.sv
// se_pkg: shared constants and types for the se core instruction memory
//   XLEN        address/register width
//   ILEN        instruction width
//   IMEM_DEPTH  instruction memory depth in words
//   NOP_INSTR   canonical NOP (addi x0,x0,0)
package se_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int IMEM_DEPTH = 1024;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef logic [XLEN-1:0] imem_addr_t;
endpackage

// File: rtl/se_imem_array.sv
// se_imem_array: DEPTH x DATA_W storage, one sync write port, one async read port
//   clk_i    in   clock, rising edge
//   we_i     in   write enable (already qualified by caller)
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   raddr_i  in   read word index
//   rdata_o  out  read data, combinational
module se_imem_array
    import se_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int DATA_W = ILEN,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    // no reset: contents must survive it
    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/se_instr_mem.sv
// se_instr_mem: fetch-stage instruction memory with range check, reset gating and NOP fill
//   clk_i       in   clock, rising edge
//   rst_i       in   sync active-high reset; blocks writes, forces NOP on instr_o
//   loadData_i  in   instruction word to store
//   loadAddr_i  in   byte address of the store
//   wrEn_i      in   store enable
//   pco_i       in   byte address of the fetch
//   instr_o     out  fetched instruction, combinational
module se_instr_mem
    import se_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = ILEN,
    parameter logic [DATA_W-1:0] NOP_INSTR = se_pkg::NOP_INSTR
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] loadData_i,
    input  logic [ADDR_W-1:0] loadAddr_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] pco_i,
    output logic [DATA_W-1:0] instr_o
);
    localparam int IDX_W = $clog2(DEPTH);

    // word addresses; byte offset bits are dropped so misaligned accesses round down
    logic [ADDR_W-1:0] w_ld_word;
    logic [ADDR_W-1:0] w_pc_word;
    logic              w_ld_in_range;
    logic              w_pc_in_range;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_ld_word = loadAddr_i >> 2;
    assign w_pc_word = pco_i >> 2;
    // any set bit above the index means out of range; no wrap-around
    assign w_ld_in_range = w_ld_word[ADDR_W-1:IDX_W] == '0;
    assign w_pc_in_range = w_pc_word[ADDR_W-1:IDX_W] == '0;
    assign w_we = !rst_i && wrEn_i && w_ld_in_range;

    se_imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (w_ld_word[IDX_W-1:0]),
        .wdata_i (loadData_i),
        .raddr_i (w_pc_word[IDX_W-1:0]),
        .rdata_o (w_rdata)
    );

    assign instr_o = (rst_i || !w_pc_in_range) ? NOP_INSTR : w_rdata;
endmodule

// File: tb/tb_se_instr_mem.sv
// tb_se_instr_mem: directed scoreboard bench for se_instr_mem
module tb_se_instr_mem;
    import se_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] load_data = '0;
    imem_addr_t  load_addr = '0;
    logic        wr_en = 1'b0;
    imem_addr_t  pco = '0;
    logic [31:0] instr;
    logic        smp = 1'b0;

    logic [31:0] exp_q [$];
    string       nm_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    se_instr_mem dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .loadData_i (load_data),
        .loadAddr_i (load_addr),
        .wrEn_i     (wr_en),
        .pco_i      (pco),
        .instr_o    (instr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // monitor: pops one expectation per sample strobe
    always @(negedge clk) begin
        if (smp) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: got %h, required a queued expectation", instr);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                n_cmp++;
                if (instr !== e) begin
                    n_err++;
                    $display("FAIL %s: pco=%h got %h required %h", n, pco, instr, e);
                end
            end
        end
    end

    task automatic expect_now(input logic [31:0] e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
        smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
    endtask

    task automatic fetch(input imem_addr_t pc, input logic [31:0] e, input string n);
        @(posedge clk);
        #1 pco = pc;
        expect_now(e, n);
    endtask

    task automatic wr(input imem_addr_t a, input logic [31:0] d);
        @(posedge clk);
        #1 wr_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    initial begin
        // reset output and write blocked under reset
        fetch(64'h0, 32'h0000_0013, "reset_nop");
        @(posedge clk);
        #1 rst = 1'b0;
        wr(64'h0, 32'h0050_0093);
        wr(64'h4, 32'h00A0_0113);
        wr(64'h8, 32'h0020_81B3);
        @(posedge clk);
        #1 rst = 1'b1;
        wr(64'h0, 32'hBAD0_BAD0);
        fetch(64'h0, 32'h0000_0013, "reset_gates_output");
        @(posedge clk);
        #1 rst = 1'b0;
        fetch(64'h0, 32'h0050_0093, "reset_write_blocked");
        fetch(64'h4, 32'h00A0_0113, "load_fetch_4");
        fetch(64'h8, 32'h0020_81B3, "load_fetch_8");
        // boundaries
        wr(64'hFFC, 32'hDEAD_BEEF);
        fetch(64'hFFC, 32'hDEAD_BEEF, "last_word");
        fetch(64'h1000, 32'h0000_0013, "past_end_nop");
        fetch(64'h8000_0000_0000_0000, 32'h0000_0013, "msb_set_nop");
        wr(64'h1000, 32'hFFFF_FFFF);
        wr(64'h1_0000_0000, 32'hEEEE_EEEE);
        fetch(64'h0, 32'h0050_0093, "oor_write_dropped");
        // misaligned
        wr(64'h10, 32'h1234_5678);
        fetch(64'h12, 32'h1234_5678, "misaligned_fetch");
        wr(64'h17, 32'hCAFE_F00D);
        fetch(64'h14, 32'hCAFE_F00D, "misaligned_write");
        // same-address read during write
        wr(64'h20, 32'h1111_1111);
        @(posedge clk);
        #1 pco = 64'h20;
        wr_en = 1'b1;
        load_addr = 64'h20;
        load_data = 32'h2222_2222;
        expect_now(32'h1111_1111, "rdw_old");
        @(posedge clk);
        #1 wr_en = 1'b0;
        expect_now(32'h2222_2222, "rdw_new");
        // retention across reset
        for (int i = 0; i < 1024; i++) wr(imem_addr_t'(i * 4), 32'(i));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 1024; i++) fetch(imem_addr_t'(i * 4), 32'(i), "retention");
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
